// File: rtl/uart_pkg.sv
// Shared UART constants and receive-capture FSM state encodings.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        CAP_IDLE     = 2'd0,
        CAP_ACK      = 2'd1,
        CAP_WAIT_LOW = 2'd2
    } cap_state_e;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy counter.
// The head entry is always visible on pop_data_o; pushes into a full FIFO
// and pops from an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      pop_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Gating uses the flags at the start of the cycle, so a same-cycle pop
    // never makes room for a push into a full FIFO.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i  & ~empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers; reset empties the FIFO.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clock_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains the receiver over its ready/ack handshake into
// a FWFT FIFO and offers the bytes downstream as a valid/ready stream.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [BYTE_W-1:0]     rx_data_i,
    input  logic                  rx_ready_i,
    output logic                  rx_ack_o,
    output logic [BYTE_W-1:0]     out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  overflow_clear_i
);

    cap_state_e state_q, state_d;
    logic       ack_q, ack_d;
    logic       overflow_q, overflow_d;
    logic       push, pop, ovf_set;
    logic       full, empty;

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i (rx_data_i),
        .pop_i       (pop),
        .pop_data_o  (out_data_o),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count_o)
    );

    assign out_valid_o = ~empty;
    assign pop         = out_valid_o & out_ready_i;
    assign rx_ack_o    = ack_q;
    assign overflow_o  = overflow_q;

    // Capture FSM: one push per receiver byte. After acking we wait for ready
    // to fall so a byte the receiver is still holding is not pushed twice.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        push    = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (rx_ready_i) begin
                    if (!full) begin
                        push    = 1'b1;
                        ack_d   = 1'b1;
                        state_d = CAP_ACK;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            CAP_ACK: begin
                state_d = CAP_WAIT_LOW;
            end
            CAP_WAIT_LOW: begin
                if (!rx_ready_i) state_d = CAP_IDLE;
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    // Sticky overflow: a set in the same cycle as a clear takes priority.
    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clear_i) overflow_d = 1'b0;
        if (ovf_set)          overflow_d = 1'b1;
    end

    // State, ack and overflow registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= CAP_IDLE;
            ack_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            overflow_q <= overflow_d;
        end
    end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: captured bytes are queued as expected
// output, and a monitor compares every accepted output byte against the queue.
module tb_uart_rx_fifo;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_ready_i = 1'b0;
    logic       rx_ack_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [4:0] count_o;
    logic       overflow_o;
    logic       overflow_clear_i = 1'b0;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .rx_data_i        (rx_data_i),
        .rx_ready_i       (rx_ready_i),
        .rx_ack_o         (rx_ack_o),
        .out_data_o       (out_data_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .count_o          (count_o),
        .overflow_o       (overflow_o),
        .overflow_clear_i (overflow_clear_i)
    );

    always #5 clock_i = ~clock_i;

    // Count ack pulses seen by the receiver.
    always @(negedge clock_i) if (!reset_i && rx_ack_o) ack_cnt++;

    // Monitor: every byte the consumer accepts must be the scoreboard head.
    always @(negedge clock_i) begin
        if (!reset_i && out_valid_o && out_ready_i) begin
            logic [7:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %02h, scoreboard empty", out_data_o);
            end else begin
                e = exp_q.pop_front();
                if (out_data_o !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %02h expected %02h", out_data_o, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    // Wait (bounded) for the ack pulse; on timeout count a failure.
    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            cyc();
            if (rx_ack_o) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
        end
    endtask

    // Receiver model: present a byte, wait for ack, keep ready high for
    // 'hold' cycles after ack, then drop it. Optionally pop in the capture cycle.
    task automatic offer(input logic [7:0] b, input int hold, input bit pop_same);
        bit got;
        rx_data_i  = b;
        rx_ready_i = 1'b1;
        if (pop_same) out_ready_i = 1'b1;
        wait_ack(got);
        if (pop_same) out_ready_i = 1'b0;
        if (got) exp_q.push_back(b);
        cyc();
        check("ack_one_cycle", rx_ack_o, 1'b0);
        for (int n = 1; n < hold; n++) cyc();
        rx_ready_i = 1'b0;
        cyc();
    endtask

    task automatic drain();
        int n = 0;
        out_ready_i = 1'b1;
        while (out_valid_o && n < 100) begin
            cyc();
            n++;
        end
        out_ready_i = 1'b0;
        check("drain_count", count_o, 5'd0);
        check("drain_scoreboard_left", exp_q.size(), 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a0;
        bit  got;

        // Reset values
        #2;
        check("rst_count", count_o, 5'd0);
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_ack", rx_ack_o, 1'b0);
        check("rst_overflow", overflow_o, 1'b0);
        cyc(); cyc();
        reset_i = 1'b0;
        cyc();

        // Single byte, ready dropped 2 cycles after ack
        a0 = ack_cnt;
        offer(8'hA5, 2, 1'b0);
        check("single_ack_pulses", ack_cnt - a0, 1);
        check("single_count", count_o, 5'd1);
        check("single_valid", out_valid_o, 1'b1);
        check("single_data", out_data_o, 8'hA5);
        out_ready_i = 1'b1; cyc(); out_ready_i = 1'b0;
        check("single_pop_count", count_o, 5'd0);
        check("single_pop_valid", out_valid_o, 1'b0);

        // Ready held for 10 cycles after ack: still one push
        a0 = ack_cnt;
        offer(8'h3C, 10, 1'b0);
        check("held_ack_pulses", ack_cnt - a0, 1);
        check("held_count", count_o, 5'd1);
        drain();

        // Fill to 16, 17th offer blocked with overflow, then admitted after a pop
        for (int i = 0; i < 16; i++) offer(8'(i), 1, 1'b0);
        check("fill_count", count_o, 5'd16);
        a0 = ack_cnt;
        rx_data_i  = 8'h10;
        rx_ready_i = 1'b1;
        repeat (4) cyc();
        check("full_no_ack", ack_cnt - a0, 0);
        check("full_overflow", overflow_o, 1'b1);
        check("full_count", count_o, 5'd16);
        out_ready_i = 1'b1; cyc(); out_ready_i = 1'b0;
        wait_ack(got);
        if (got) exp_q.push_back(8'h10);
        check("refill_count", count_o, 5'd16);
        cyc();
        rx_ready_i = 1'b0;
        cyc();
        drain();

        // Overflow clear, then clear colliding with a new full offer
        check("ovf_sticky", overflow_o, 1'b1);
        overflow_clear_i = 1'b1; cyc(); overflow_clear_i = 1'b0;
        check("ovf_cleared", overflow_o, 1'b0);
        for (int i = 0; i < 16; i++) offer(8'h20 + 8'(i), 1, 1'b0);
        rx_data_i        = 8'h99;
        rx_ready_i       = 1'b1;
        overflow_clear_i = 1'b1;
        cyc();
        overflow_clear_i = 1'b0;
        check("ovf_set_wins", overflow_o, 1'b1);
        rx_ready_i = 1'b0;
        cyc();
        check("ovf_no_push", count_o, 5'd16);
        drain();
        overflow_clear_i = 1'b1; cyc(); overflow_clear_i = 1'b0;

        // Simultaneous push and pop at count 5, streamed across pointer wrap
        for (int i = 0; i < 5; i++) offer(8'h40 + 8'(i), 1, 1'b0);
        check("stream_base_count", count_o, 5'd5);
        for (int i = 0; i < 40; i++) begin
            offer(8'h50 + 8'(i), 1, 1'b1);
            check("stream_count", count_o, 5'd5);
        end
        drain();

        // Asynchronous reset in CAP_ACK with 3 bytes stored
        for (int i = 0; i < 3; i++) offer(8'hC0 + 8'(i), 1, 1'b0);
        rx_data_i  = 8'h77;
        rx_ready_i = 1'b1;
        wait_ack(got);
        reset_i = 1'b1;
        #1;
        check("arst_count", count_o, 5'd0);
        check("arst_ack", rx_ack_o, 1'b0);
        check("arst_valid", out_valid_o, 1'b0);
        exp_q.delete();
        cyc(); cyc();
        reset_i = 1'b0;
        // Receiver still holds the byte, so it is captured again
        wait_ack(got);
        if (got) exp_q.push_back(8'h77);
        check("recapture_count", count_o, 5'd1);
        rx_ready_i = 1'b0;
        cyc(); cyc();
        drain();

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
